// File: rtl/step_sequencer_ctrl_if.sv
// rtl/step_sequencer_ctrl_if.sv - pattern configuration bus into the step sequencer
interface step_sequencer_ctrl_if #(
    parameter int NUM_TRACKS = 4,
    parameter int STEPS      = 8
) ();
    localparam int TRK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

    logic             cfg_wr;
    logic [TRK_W-1:0] cfg_track;
    logic [STEPS-1:0] cfg_pattern;

    modport master (output cfg_wr, cfg_track, cfg_pattern);
    modport slave  (input  cfg_wr, cfg_track, cfg_pattern);
endinterface

// File: rtl/step_sequencer_ctrl.sv
// rtl/step_sequencer_ctrl.sv - tempo counter, beat index, per-track gates and bar-aligned pattern edits
module step_sequencer_ctrl #(
    parameter int NUM_TRACKS     = 4,
    parameter int STEPS          = 8,
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = 12500000,
    parameter int DEFAULT_GATE   = 6250000,
    localparam int BEAT_W        = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      period_in,
    input  logic [CNT_W-1:0]      gate_in,
    step_sequencer_ctrl_if.slave  cfg,
    input  logic [NUM_TRACKS-1:0] mute,
    output logic [1:0]            state,
    output logic [BEAT_W-1:0]     beat,
    output logic                  step_tick,
    output logic                  bar_tick,
    output logic [NUM_TRACKS-1:0] gate
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(STEPS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q, gate_len_q;
    logic [CNT_W-1:0]      period_s, gate_s;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  step_start, bar_start;
    logic [NUM_TRACKS-1:0] gate_d;
    logic [STEPS-1:0]      pat_q    [NUM_TRACKS];
    logic [STEPS-1:0]      shadow_q [NUM_TRACKS];
    logic [STEPS-1:0]      eff_pat  [NUM_TRACKS];
    logic [NUM_TRACKS-1:0] pend_q;
    logic                  cfg_hit;

    assign state   = state_q;
    assign beat    = beat_q;
    assign cfg_hit = cfg.cfg_wr && (int'(cfg.cfg_track) < NUM_TRACKS);

    always_comb begin
        period_s = (period_in < CNT_TWO) ? CNT_TWO : period_in;
        gate_s   = (gate_in > period_s - CNT_ONE) ? period_s - CNT_ONE : gate_in;
    end

    always_comb begin
        state_d = state_q;
        if (stop)
            state_d = S_IDLE;
        else if (pause && state_q == S_RUN)
            state_d = S_PAUSE;
        else if (start && state_q != S_RUN)
            state_d = S_RUN;
    end

    // The edge that leaves RUN still completes that cycle's count, so a pause
    // on the last cycle of a step freezes at counter 0 and resume opens a fresh step.
    always_comb begin
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        step_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_RUN) begin
                    cnt_d      = '0;
                    beat_d     = '0;
                    step_start = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == period_q - CNT_ONE) begin
                    cnt_d      = '0;
                    beat_d     = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_ONE;
                    step_start = (state_d == S_RUN);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PAUSE: begin
                if (state_d == S_RUN)
                    step_start = (cnt_q == '0);
            end
            default: ;
        endcase
        if (state_d == S_IDLE) begin
            cnt_d  = '0;
            beat_d = '0;
        end
        bar_start = step_start && (beat_d == '0);
    end

    // A bar-opening step already plays the pending shadows it commits.
    always_comb begin
        gate_d = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            eff_pat[t] = (bar_start && pend_q[t]) ? shadow_q[t] : pat_q[t];
            if (step_start)
                gate_d[t] = eff_pat[t][beat_d] & ~mute[t] & (gate_s != '0);
            else if (state_q == S_RUN && state_d == S_RUN)
                gate_d[t] = gate[t] & (cnt_d < gate_len_q);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            period_q   <= CNT_W'(DEFAULT_PERIOD);
            gate_len_q <= CNT_W'(DEFAULT_GATE);
            step_tick  <= 1'b0;
            bar_tick   <= 1'b0;
            gate       <= '0;
            pend_q     <= '0;
            for (int t = 0; t < NUM_TRACKS; t++) begin
                pat_q[t]    <= '0;
                shadow_q[t] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            step_tick <= step_start;
            bar_tick  <= bar_start;
            gate      <= gate_d;
            if (step_start) begin
                period_q   <= period_s;
                gate_len_q <= gate_s;
            end
            if (bar_start) begin
                for (int t = 0; t < NUM_TRACKS; t++)
                    if (pend_q[t])
                        pat_q[t] <= shadow_q[t];
            end
            pend_q <= bar_start ? '0 : pend_q;
            if (cfg_hit && state_q != S_RUN)
                pat_q[cfg.cfg_track] <= cfg.cfg_pattern;
            if (cfg_hit && state_q == S_RUN) begin
                shadow_q[cfg.cfg_track] <= cfg.cfg_pattern;
                pend_q[cfg.cfg_track]   <= 1'b1;
            end
            if (stop)
                pend_q <= '0;
        end
    end
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb/tb_step_sequencer_ctrl.sv - scoreboard bench for step_sequencer_ctrl
module tb_step_sequencer_ctrl;
    localparam int NT = 4;
    localparam int ST = 8;
    localparam int CW = 24;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic          pause    = 1'b0;
    logic          stop     = 1'b0;
    logic [CW-1:0] period_in;
    logic [CW-1:0] gate_in;
    logic [NT-1:0] mute;
    logic [1:0]    state;
    logic [2:0]    beat;
    logic          step_tick;
    logic          bar_tick;
    logic [NT-1:0] gate;

    step_sequencer_ctrl_if #(.NUM_TRACKS(NT), .STEPS(ST)) cfg_bus ();

    step_sequencer_ctrl #(
        .NUM_TRACKS(NT),
        .STEPS     (ST),
        .CNT_W     (CW)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .period_in(period_in),
        .gate_in  (gate_in),
        .cfg      (cfg_bus),
        .mute     (mute),
        .state    (state),
        .beat     (beat),
        .step_tick(step_tick),
        .bar_tick (bar_tick),
        .gate     (gate)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int beat;
        int mask;
        int len;
        int gap;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_cyc = 0;
    int   gcnt  = 0;
    int   prev_len = 0;
    bit   have_prev = 0;
    bit   flush_req = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int b, input int m, input int l, input int g);
        exp_t e;
        e.beat = b;
        e.mask = m;
        e.len  = l;
        e.gap  = g;
        sbq.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic pulse(input bit s, input bit p, input bit t);
        start = s;
        pause = p;
        stop  = t;
        cycles(1);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic write_pat(input int trk, input logic [7:0] p);
        cfg_bus.cfg_wr      = 1'b1;
        cfg_bus.cfg_track   = 2'(trk);
        cfg_bus.cfg_pattern = p;
        cycles(1);
        cfg_bus.cfg_wr      = 1'b0;
    endtask

    task automatic flush();
        flush_req = 1'b1;
        cycles(2);
    endtask

    // Monitor: every step_tick consumes one expected step; the gate-high count
    // of a step is closed out at the next tick or at an explicit flush.
    always @(negedge CLOCK_50) begin
        exp_t e;
        cyc++;
        if (flush_req) begin
            if (have_prev)
                chk("gate_len", gcnt, prev_len);
            have_prev = 0;
            flush_req = 0;
        end else if (step_tick) begin
            if (have_prev)
                chk("gate_len", gcnt, prev_len);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got tick at beat %0d, required no tick", beat);
                have_prev = 0;
            end else begin
                e = sbq.pop_front();
                chk("beat", int'(beat), e.beat);
                chk("bar_tick", int'(bar_tick), int'(e.beat == 0));
                chk("gate_mask", int'(gate), e.mask);
                if (e.gap != 0)
                    chk("step_gap", cyc - last_cyc, e.gap);
                prev_len  = e.len;
                have_prev = 1;
            end
            last_cyc = cyc;
            gcnt     = int'(gate != 0);
        end else begin
            if (gate != 0)
                gcnt++;
            if (bar_tick) begin
                total++;
                bad++;
                $display("FAIL stray_bar_tick: got bar_tick=1 without step_tick, required 0");
            end
        end
    end

    function automatic int m1(input int b);
        return (b == 0 || b == 2) ? 1 : 0;
    endfunction

    initial begin
        int b;
        period_in           = 10;
        gate_in             = 4;
        mute                = '0;
        cfg_bus.cfg_wr      = 1'b0;
        cfg_bus.cfg_track   = '0;
        cfg_bus.cfg_pattern = '0;

        // reset defaults
        cycles(2);
        chk("rst_state", int'(state), 0);
        chk("rst_beat", int'(beat), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_step_tick", int'(step_tick), 0);
        chk("rst_bar_tick", int'(bar_tick), 0);
        reset_n = 1'b1;
        cycles(1);

        // basic run: period 10, gate 4, track 0 on beats 0 and 2
        write_pat(0, 8'b0000_0101);
        for (int i = 0; i < 9; i++) begin
            b = i % 8;
            push(b, m1(b), m1(b) * 4, (i == 0) ? 0 : 10);
        end
        pulse(1, 0, 0);
        chk("start_state", int'(state), 1);
        chk("start_beat", int'(beat), 0);
        cycles(85);
        pulse(0, 0, 1);
        chk("stop_state", int'(state), 0);
        chk("stop_beat", int'(beat), 0);
        chk("stop_gate", int'(gate), 0);
        flush();

        // clamp: period 0 -> 2, gate 5 -> 1
        period_in = 0;
        gate_in   = 5;
        for (int i = 0; i < 9; i++) begin
            b = i % 8;
            push(b, m1(b), m1(b), (i == 0) ? 0 : 2);
        end
        pulse(1, 0, 0);
        cycles(17);
        pulse(0, 0, 1);
        flush();

        // clamp: gate 20 with period 6 -> 5
        period_in = 6;
        gate_in   = 20;
        push(0, 1, 5, 0);
        push(1, 0, 0, 6);
        push(2, 1, 5, 6);
        pulse(1, 0, 0);
        cycles(16);
        pulse(0, 0, 1);
        flush();

        // deferred edit at beat 3 plus mid-step mute of track 2
        period_in = 10;
        gate_in   = 4;
        write_pat(1, 8'h00);
        write_pat(2, 8'hFF);
        push(0, 5, 4, 0);
        push(1, 4, 4, 10);
        push(2, 5, 4, 10);
        push(3, 4, 4, 10);
        push(4, 0, 0, 10);
        push(5, 0, 0, 10);
        push(6, 0, 0, 10);
        push(7, 0, 0, 10);
        push(0, 3, 4, 10);
        push(1, 2, 4, 10);
        push(2, 3, 4, 10);
        pulse(1, 0, 0);
        cycles(32);
        mute = 4'b0100;
        write_pat(1, 8'hFF);
        cycles(72);
        pulse(0, 0, 1);
        mute = '0;
        flush();

        // pause at counter 3 of beat 5, resume 50 cycles later
        gate_in = 6;
        write_pat(1, 8'h20);
        write_pat(2, 8'h00);
        push(0, 1, 6, 0);
        push(1, 0, 0, 10);
        push(2, 1, 6, 10);
        push(3, 0, 0, 10);
        push(4, 0, 0, 10);
        push(5, 2, 4, 10);
        push(6, 0, 0, 61);
        push(7, 0, 0, 10);
        push(0, 1, 6, 10);
        pulse(1, 0, 0);
        cycles(53);
        pulse(0, 1, 0);
        chk("pause_state", int'(state), 2);
        chk("pause_gate", int'(gate), 0);
        cycles(50);
        chk("pause_hold_beat", int'(beat), 5);
        chk("pause_hold_state", int'(state), 2);
        pulse(1, 0, 0);
        chk("resume_state", int'(state), 1);
        chk("resume_beat", int'(beat), 5);
        chk("resume_no_tick", int'(step_tick), 0);
        chk("resume_no_gate", int'(gate), 0);
        cycles(33);
        pulse(0, 0, 1);
        flush();

        // stop+pause+start together discards a pending write to track 3
        gate_in = 4;
        push(0, 1, 4, 0);
        push(1, 0, 0, 10);
        pulse(1, 0, 0);
        cycles(12);
        write_pat(3, 8'hFF);
        cycles(2);
        pulse(1, 1, 1);
        chk("prio_state", int'(state), 0);
        chk("prio_beat", int'(beat), 0);
        flush();

        for (int i = 0; i < 9; i++) begin
            b = i % 8;
            push(b, m1(b) + ((b == 5) ? 2 : 0), (i == 8) ? 2 : ((m1(b) != 0 || b == 5) ? 4 : 0),
                 (i == 0) ? 0 : 10);
        end
        pulse(1, 0, 0);
        cycles(81);
        reset_n = 1'b0;
        cycles(1);
        chk("abort_gate", int'(gate), 0);
        chk("abort_state", int'(state), 0);
        chk("abort_tick", int'(step_tick), 0);
        chk("abort_beat", int'(beat), 0);
        reset_n = 1'b1;
        flush();

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
